riscv_cpu_div_ctrl: RTL and testbench
=====================================

# riscv_cpu_div_ctrl

Multi-cycle divide/remainder unit for the execute stage. Sequences a radix-2 restoring shift-subtract datapath for the four ALU divide opcodes `ALU_DIVU`, `ALU_DIV`, `ALU_REMU` and `ALU_REM`. It sits beside the single-cycle ALU: the execute stage hands it operands through a valid/ready handshake and stalls until the result handshake completes. Results follow RISC-V M-extension semantics, including division by zero and signed overflow.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be a power of two, ≥8.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous reset, active-high.
- `operator_i` in 7: `alu_opcode_e`.
  - Bits [6:2] must be 5'b01100, otherwise `valid_i` is ignored.
  - Bit 0: signed.
  - Bit 1: remainder.
- `op_a_i` in DATA_WIDTH: dividend.
- `op_b_i` in DATA_WIDTH: divisor.
- `valid_i` in 1: request valid.
- `ready_o` out 1: request accepted when high with `valid_i`.
- `result_o` out DATA_WIDTH: quotient or remainder.
- `valid_o` out 1: result valid.
- `ready_i` in 1: consumer takes result.
- `kill_i` in 1: flush; abort any operation.

## Operation
- States: IDLE, PREP, DIV, FIX, DONE. Reset enters IDLE.
- IDLE:
  - `ready_o`=1.
  - On `valid_i & ready_o` with a legal opcode: latch the opcode flags and the operands, record the operand signs (signed ops only), then go to PREP.
- PREP:
  - Replace the operands by their absolute values (signed ops).
  - Clear the remainder register and load the counter with DATA_WIDTH-1.
  - Go to DIV.
- DIV, one quotient bit per cycle:
  - rem = {rem[W-2:0], dvd[W-1]}; dvd <<= 1.
  - If rem ≥ divisor: rem -= divisor and the quotient bit is 1; otherwise 0.
  - Compare/subtract is W+1 bits wide (unsigned).
  - Counter decrements; on 0 go to FIX.
- FIX:
  - Negate the quotient if the operand signs differed.
  - Negate the remainder if the dividend was negative.
  - Select quotient or remainder into the result register, then go to DONE.
- DONE:
  - `valid_o`=1 and `result_o` held stable.
  - On `ready_i`: go to IDLE.
  - `ready_o`=0 in all states except IDLE.
- Required results:
  - Divide by zero: quotient all-ones, remainder = dividend. Falls out of the datapath naturally for unsigned. For signed, the quotient sign fix is suppressed when the divisor is 0.
  - Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. Falls out naturally from the absolute-value arithmetic.
- `kill_i`:
  - Any state goes to IDLE on the next edge; `valid_o` drops on that edge.
  - In IDLE, `kill_i` blocks acceptance even if `valid_i`=1.
- `rst_i` mid-operation: immediate return to IDLE, all registers cleared.
- Reset values: `ready_o`=1, `valid_o`=0, `result_o`=0. Internal registers are 0.

## Timing
- Request accepted at edge E0. State sequence: PREP (1 cycle), DIV (DATA_WIDTH cycles), FIX (1 cycle).
- `valid_o` first high DATA_WIDTH+3 cycles after the accept cycle (35 for W=32).
- Result handshake at edge En. `ready_o` is high in the cycle after En, so the minimum issue interval is DATA_WIDTH+4 cycles.
- No combinational path from `valid_i`/`ready_i`/`kill_i` to `valid_o` or `result_o`. `ready_o` is decoded from state only.
- Operand inputs are sampled only at the accept edge; later changes are ignored.

## Configuration
- `RISCV_CPU_DIV_FAST_EN` defined:
  - A divisor of zero or a signed-overflow request goes from IDLE directly to DONE with the architected result.
  - `valid_o` is high in the cycle after acceptance.
- Undefined: every request takes the full DATA_WIDTH+3-cycle path with identical results.

## Test plan
- DIVU 100/7 → `result_o`=14, `valid_o` rises exactly 35 cycles after accept; REMU 100/7 → 2.
- DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - Latency is 1 with `RISCV_CPU_DIV_FAST_EN`, 35 without.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: hold `ready_i`=0 for 5 cycles in DONE.
  - `valid_o` and `result_o` remain stable and `ready_o` stays 0.
  - After the handshake, `ready_o`=1 in the next cycle.
- Assert `kill_i` in DIV cycle 10.
  - Next cycle: IDLE, `ready_o`=1, `valid_o` never asserted.
  - A following DIVU 9/3 returns 3 correctly.
- Assert `rst_i` asynchronously mid-DIV.
  - Outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_cpu_div_ctrl.sv
// Multi-cycle radix-2 restoring divide/remainder unit (DIV, DIVU, REM, REMU) with RISC-V M semantics.
// Optional macro RISCV_CPU_DIV_FAST_EN: divide-by-zero and signed overflow bypass the iteration.
module riscv_cpu_div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            operator_i,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  kill_i
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] dvd_q;     // dividend, becomes the quotient as bits shift in
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [CW-1:0]         cnt_q;
    logic                  is_rem_q;
    logic                  neg_a_q;
    logic                  neg_b_q;

    logic                  accept;
    logic                  fast_hit;
    logic [DATA_WIDTH-1:0] fast_result;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;
    logic                  quo_neg;

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;
    assign accept   = ready_o & valid_i & ~kill_i & (operator_i[6:2] == 5'b01100);

`ifdef RISCV_CPU_DIV_FAST_EN
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic div_zero;
    logic overflow;

    always_comb begin
        div_zero = (op_b_i == '0);
        overflow = operator_i[0] && (op_a_i == MOST_NEG) && (op_b_i == '1);
        fast_hit = div_zero | overflow;
        if (operator_i[1]) fast_result = div_zero ? op_a_i : '0;
        else               fast_result = div_zero ? '1 : MOST_NEG;
    end
`else
    assign fast_hit    = 1'b0;
    assign fast_result = '0;
`endif

    // The shifted partial remainder keeps its top bit so divisors above 2^(W-1) still compare correctly.
    assign rem_shift = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    // A zero divisor leaves the all-ones quotient unsigned, as the architecture requires.
    assign quo_neg   = (neg_a_q ^ neg_b_q) && (dvs_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = fast_hit ? S_DONE : S_PREP;
            S_PREP: state_d = S_DIV;
            S_DIV:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill_i) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept) begin
                    is_rem_q <= operator_i[1];
                    neg_a_q  <= operator_i[0] & op_a_i[DATA_WIDTH-1];
                    neg_b_q  <= operator_i[0] & op_b_i[DATA_WIDTH-1];
                    dvd_q    <= op_a_i;
                    dvs_q    <= op_b_i;
                    if (fast_hit) result_q <= fast_result;
                end
                S_PREP: begin
                    if (neg_a_q) dvd_q <= -dvd_q;
                    if (neg_b_q) dvs_q <= -dvs_q;
                    rem_q <= '0;
                    cnt_q <= CW'(DATA_WIDTH - 1);
                end
                S_DIV: begin
                    if (!rem_diff[DATA_WIDTH]) begin
                        rem_q <= rem_diff[DATA_WIDTH-1:0];
                        dvd_q <= {dvd_q[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift[DATA_WIDTH-1:0];
                        dvd_q <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    if (is_rem_q) result_q <= neg_a_q ? -rem_q : rem_q;
                    else          result_q <= quo_neg ? -dvd_q : dvd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_cpu_div_ctrl.sv
// Directed, table-driven bench for riscv_cpu_div_ctrl plus backpressure, kill and async-reset sequences.
module tb_riscv_cpu_div_ctrl;

    localparam int W = 32;
    localparam logic [6:0] DIVU = 7'h30;
    localparam logic [6:0] DIV  = 7'h31;
    localparam logic [6:0] REMU = 7'h32;
    localparam logic [6:0] REM  = 7'h33;
`ifdef RISCV_CPU_DIV_FAST_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = W + 3;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [6:0]   operator_i;
    logic [W-1:0] op_a_i, op_b_i;
    logic         valid_i, ready_o, valid_o, ready_i, kill_i;
    logic [W-1:0] result_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    riscv_cpu_div_ctrl #(.DATA_WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .operator_i (operator_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .kill_i     (kill_i)
    );

    typedef struct {
        string        name;
        logic [6:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit fast;
        fast = (b == '0) || (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return fast ? FAST_LAT : W + 3;
    endfunction

    task automatic issue(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk_i);
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        valid_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i    = 1'b0;
        operator_i = DIVU;
        op_a_i     = 32'h1234_5678;
        op_b_i     = 32'h0000_0003;
    endtask

    task automatic wait_valid(output int lat, output bit busy_bad);
        lat      = 1;
        busy_bad = 1'b0;
        while (!valid_o && lat < 200) begin
            if (ready_o) busy_bad = 1'b1;
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check({name, "_hs_ready_valid"}, {30'd0, ready_o, valid_o}, 32'd2);
    endtask

    initial begin
        int  lat;
        bit  busy_bad;
        bit  seen;

        vecs[0]  = '{"divu_100_7",    DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{"remu_100_7",    REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{"div_m7_2",      DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{"rem_m7_2",      REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{"rem_7_m2",      REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[5]  = '{"div_7_m2",      DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[6]  = '{"div_5_0",       DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{"remu_5_0",      REMU, 32'd5,          32'd0,          32'd5};
        vecs[8]  = '{"div_ovf",       DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[9]  = '{"rem_ovf",       REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[10] = '{"divu_big_dvs",  DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1};
        vecs[11] = '{"remu_big_dvs",  REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE};
        vecs[12] = '{"rem_m5_0",      REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[13] = '{"div_m7_m2",     DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3};
        vecs[14] = '{"divu_no_ovf",   DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[15] = '{"rem_m7_m2",     REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF};

        rst_i      = 1'b1;
        operator_i = DIVU;
        op_a_i     = '0;
        op_b_i     = '0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        kill_i     = 1'b0;
        #12;
        check("reset_ready",  {31'd0, ready_o}, 32'd1);
        check("reset_valid",  {31'd0, valid_o}, 32'd0);
        check("reset_result", result_o,         32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat, busy_bad);
            check(vecs[i].name, result_o, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
            check({vecs[i].name, "_ready_busy"}, {31'd0, busy_bad}, 32'd0);
            handshake(vecs[i].name);
        end

        // Backpressure: result must stay put while the consumer stalls.
        issue(DIVU, 32'd100, 32'd7);
        wait_valid(lat, busy_bad);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i);
            #1;
            check("bp_valid",  {31'd0, valid_o}, 32'd1);
            check("bp_result", result_o,         32'd14);
            check("bp_ready",  {31'd0, ready_o}, 32'd0);
        end
        handshake("bp");

        // Kill during the tenth DIV cycle.
        issue(DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        check("kill_ready", {31'd0, ready_o}, 32'd1);
        check("kill_valid", {31'd0, valid_o}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen = 1'b1;
        end
        check("kill_no_valid", {31'd0, seen}, 32'd0);
        issue(DIVU, 32'd9, 32'd3);
        wait_valid(lat, busy_bad);
        check("after_kill_divu_9_3", result_o, 32'd3);
        check("after_kill_latency",  lat,      W + 3);
        handshake("after_kill");

        // Kill in IDLE blocks acceptance.
        @(negedge clk_i);
        operator_i = DIVU;
        op_a_i     = 32'd50;
        op_b_i     = 32'd5;
        valid_i    = 1'b1;
        kill_i     = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        kill_i  = 1'b0;
        check("idle_kill_ready", {31'd0, ready_o}, 32'd1);

        // Illegal opcode is ignored.
        @(negedge clk_i);
        operator_i = 7'h34;
        valid_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("illegal_op_ready", {31'd0, ready_o}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o || !ready_o) seen = 1'b1;
        end
        check("illegal_op_idle", {31'd0, seen}, 32'd0);

        // Asynchronous reset mid-DIV; result register still holds 3 from the earlier 9/3.
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_ready",  {31'd0, ready_o}, 32'd1);
        check("arst_valid",  {31'd0, valid_o}, 32'd0);
        check("arst_result", result_o,         32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        issue(DIVU, 32'd100, 32'd7);
        wait_valid(lat, busy_bad);
        check("after_rst_divu", result_o, 32'd14);
        handshake("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
